wormhole_output_allocator: RTL and testbench

//  Output-port allocator for the router switch. Shares one output port between IN_N

---
 rtl/wormhole_output_allocator_if.sv | 23 ++
 rtl/wormhole_output_allocator.sv | 99 +++++++++
 tb/tb_wormhole_output_allocator.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wormhole_output_allocator_if.sv
// Request/grant bundle shared by the input buffers, the output-port allocator and the crossbar.
interface wormhole_output_allocator_if #(
    parameter int IN_N  = 5,
    parameter int IDX_W = $clog2(IN_N)
);
    logic [IN_N-1:0]  req_i;
    logic [IN_N-1:0]  last_i;
    logic             out_rdy_i;
    logic [IDX_W-1:0] grant_o;
    logic [IN_N-1:0]  grant_oh_o;
    logic             grant_vld_o;
    logic [IN_N-1:0]  ack_o;

    modport slave (
        input  req_i, last_i, out_rdy_i,
        output grant_o, grant_oh_o, grant_vld_o, ack_o
    );

    modport master (
        output req_i, last_i, out_rdy_i,
        input  grant_o, grant_oh_o, grant_vld_o, ack_o
    );
endinterface

// File: rtl/wormhole_output_allocator.sv
// Round-robin output-port allocator with wormhole locking: an input keeps the port
// until its tail flit transfers, and the next packet is granted on that same edge.
module wormhole_output_allocator #(
    parameter int  IN_N  = 5,
    localparam int IDX_W = $clog2(IN_N)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    wormhole_output_allocator_if.slave   bus
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] nxt_idx;
    logic [IN_N-1:0]  own_oh;
    logic [IDX_W:0]   pick_all;
    logic [IDX_W:0]   pick_oth;
    logic             xfer;

    // Returns {found, index} of the first set bit scanning start, start+1, ... with wrap.
    function automatic logic [IDX_W:0] pick(input logic [IN_N-1:0] req,
                                            input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < IN_N; i++) begin
            k = int'(start) + i;
            if (k >= IN_N) k = k - IN_N;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
        return {found, idx};
    endfunction

    assign own_oh   = IN_N'(1) << grant_q;
    assign nxt_idx  = (grant_q == IDX_W'(IN_N - 1)) ? '0 : grant_q + IDX_W'(1);
    assign pick_all = pick(bus.req_i, ptr_q);
    // The releasing owner is masked so a re-requesting tail owner goes to the back of the line.
    assign pick_oth = pick(bus.req_i & ~own_oh, nxt_idx);

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        ptr_d           = ptr_q;
        xfer            = 1'b0;
        bus.grant_o     = grant_q;
        bus.grant_vld_o = 1'b0;
        bus.grant_oh_o  = '0;
        bus.ack_o       = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_all[IDX_W]) begin
                    grant_d = pick_all[IDX_W-1:0];
                    state_d = LOCKED;
                end
            end

            LOCKED: begin
                bus.grant_vld_o = 1'b1;
                bus.grant_oh_o  = own_oh;
                xfer            = bus.req_i[grant_q] & bus.out_rdy_i;
                if (xfer) begin
                    bus.ack_o = own_oh;
                    if (bus.last_i[grant_q]) begin
                        ptr_d = nxt_idx;
                        if (pick_oth[IDX_W]) begin
                            grant_d = pick_oth[IDX_W-1:0];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Scoreboard bench for the wormhole output allocator: per-input packet sources, expected
// (input, flit) pops queued at stimulus time, plus invariant, wormhole and fairness checks.
module tb_wormhole_output_allocator;
    localparam int IN_N = 5;

    typedef struct {
        int src;
        int flit;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    wormhole_output_allocator_if #(.IN_N(IN_N)) bus ();

    wormhole_output_allocator #(.IN_N(IN_N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad   = 0;
    int              rem   [IN_N];
    int              sent  [IN_N];
    int              plen  [IN_N];
    int              pkts  [IN_N];
    int              waitp [IN_N];
    logic [IN_N-1:0] hold;
    int              owner;
    int              last_src;
    bit              sb_on;
    exp_t            sbq[$];

    task automatic drive();
        logic [IN_N-1:0] r;
        logic [IN_N-1:0] l;
        for (int i = 0; i < IN_N; i++) begin
            r[i] = (rem[i] > 0) && !hold[i];
            l[i] = (rem[i] == 1);
        end
        bus.req_i  = r;
        bus.last_i = l;
    endtask

    task automatic clear_bench();
        for (int i = 0; i < IN_N; i++) begin
            rem[i] = 0; sent[i] = 0; plen[i] = 0; pkts[i] = 0; waitp[i] = 0;
        end
        hold     = '0;
        owner    = -1;
        last_src = -1;
        sbq.delete();
    endtask

    task automatic load(input int src, input int len, input int n);
        rem[src]  = len;
        sent[src] = 0;
        plen[src] = len;
        pkts[src] = n - 1;
        drive();
    endtask

    task automatic push_pkt(input int src, input int nflits);
        exp_t e;
        for (int f = 0; f < nflits; f++) begin
            e.src  = src;
            e.flit = f;
            sbq.push_back(e);
        end
    endtask

    // Samples the settled outputs, checks them, then advances one clock and retires the flit.
    task automatic clk_cycle();
        int              src;
        exp_t            e;
        logic [IN_N-1:0] oh;
        #1;
        src = -1;
        for (int i = 0; i < IN_N; i++) if (bus.ack_o[i]) src = i;
        oh = '0;
        oh[bus.grant_o] = 1'b1;
        total++;
        if (!$onehot0(bus.ack_o) || (bus.ack_o !== '0 && bus.grant_vld_o !== 1'b1) ||
            ((bus.grant_oh_o !== '0) !== bus.grant_vld_o) ||
            (bus.grant_vld_o === 1'b1 && bus.grant_oh_o !== oh)) begin
            bad++;
            $display("FAIL invariants: ack=%b vld=%b oh=%b grant=%0d", bus.ack_o,
                     bus.grant_vld_o, bus.grant_oh_o, bus.grant_o);
        end
        if (src >= 0) begin
            total++;
            if (src !== int'(bus.grant_o) || (owner >= 0 && src !== owner) || rem[src] <= 0) begin
                bad++;
                $display("FAIL ack_owner: ack input %0d, required grant %0d owner %0d pending %0d",
                         src, bus.grant_o, owner, rem[src]);
            end
            if (sb_on) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: ack input %0d flit %0d, required no ack", src, sent[src]);
                end else begin
                    e = sbq.pop_front();
                    if (e.src !== src || e.flit !== sent[src]) begin
                        bad++;
                        $display("FAIL sb_order: got input %0d flit %0d, required input %0d flit %0d",
                                 src, sent[src], e.src, e.flit);
                    end
                end
            end
            if (bus.last_i[src]) begin
                owner = -1;
                for (int i = 0; i < IN_N; i++) begin
                    if (i != src && bus.req_i[i]) begin
                        waitp[i]++;
                        total++;
                        if (waitp[i] > IN_N - 1) begin
                            bad++;
                            $display("FAIL fairness: input %0d waited %0d packets, required <= %0d",
                                     i, waitp[i], IN_N - 1);
                        end
                    end
                end
            end else begin
                owner = src;
            end
            waitp[src] = 0;
        end
        last_src = src;
        @(posedge clk);
        @(negedge clk);
        if (src >= 0) begin
            rem[src]--;
            sent[src]++;
            if (rem[src] == 0 && pkts[src] > 0) begin
                pkts[src]--;
                rem[src]  = plen[src];
                sent[src] = 0;
            end
        end
        drive();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < max) begin
            clk_cycle();
            n++;
        end
        total++;
        if (sbq.size() !== 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d flits outstanding after %0d cycles, required 0", sbq.size(), max);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_bench();
        bus.out_rdy_i = 1'b1;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_bench();
        bus.out_rdy_i = 1'b1;
        drive();
        #1;
        total++;
        if ({bus.grant_o, bus.grant_oh_o, bus.grant_vld_o, bus.ack_o} !== '0) begin
            bad++;
            $display("FAIL reset_init: grant=%0d oh=%b vld=%b ack=%b, required all 0",
                     bus.grant_o, bus.grant_oh_o, bus.grant_vld_o, bus.ack_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        load(2, 1, 1); push_pkt(2, 1);
        clk_cycle();
        clk_cycle();
        load(3, 4, 1); push_pkt(3, 2);
        repeat (3) clk_cycle();
        #1;
        total++;
        if (bus.grant_vld_o !== 1'b1 || bus.grant_o !== 3'd3 || bus.ack_o !== 5'b01000) begin
            bad++;
            $display("FAIL reset_pre_lock: vld=%b grant=%0d ack=%b, required 1 3 01000",
                     bus.grant_vld_o, bus.grant_o, bus.ack_o);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.grant_o, bus.grant_oh_o, bus.grant_vld_o, bus.ack_o} !== '0) begin
            bad++;
            $display("FAIL reset_midpkt: grant=%0d oh=%b vld=%b ack=%b, required all 0",
                     bus.grant_o, bus.grant_oh_o, bus.grant_vld_o, bus.ack_o);
        end
        total++;
        if (sbq.size() !== 0) begin
            bad++;
            $display("FAIL reset_sb: %0d flits outstanding, required 0", sbq.size());
        end
        @(posedge clk);
        @(negedge clk);
        clear_bench();
        drive();
        rst = 1'b0;
        // Pointer must be back at 0: inputs 1 and 4 compete, 1 must win.
        load(1, 1, 1); load(4, 1, 1);
        push_pkt(1, 1); push_pkt(4, 1);
        clk_cycle();
        #1;
        total++;
        if (bus.grant_vld_o !== 1'b1 || bus.grant_o !== 3'd1) begin
            bad++;
            $display("FAIL reset_ptr: vld=%b grant=%0d, required 1 1", bus.grant_vld_o, bus.grant_o);
        end
        drain(10);
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(2, 3, 1); load(4, 3, 1);
        push_pkt(2, 3); push_pkt(4, 3);
        clk_cycle();
        #1;
        total++;
        if (bus.grant_vld_o !== 1'b1 || bus.grant_o !== 3'd2) begin
            bad++;
            $display("FAIL b2b_first_grant: vld=%b grant=%0d, required 1 2", bus.grant_vld_o, bus.grant_o);
        end
        for (int c = 0; c < 6; c++) begin
            clk_cycle();
            total++;
            if (last_src < 0) begin
                bad++;
                $display("FAIL b2b_bubble: no ack in cycle %0d, required an ack", c);
            end
        end
        total++;
        if (sbq.size() !== 0 || bus.grant_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release: outstanding=%0d vld=%b, required 0 0", sbq.size(), bus.grant_vld_o);
        end
        load(0, 1, 1); load(2, 1, 1);
        push_pkt(0, 1); push_pkt(2, 1);
        clk_cycle();
        #1;
        total++;
        if (bus.grant_vld_o !== 1'b1 || bus.grant_o !== 3'd0) begin
            bad++;
            $display("FAIL b2b_wrap: vld=%b grant=%0d, required 1 0", bus.grant_vld_o, bus.grant_o);
        end
        drain(10);
    endtask

    task automatic test_backpressure();
        do_reset();
        load(1, 4, 1); push_pkt(1, 4);
        clk_cycle();
        clk_cycle();
        bus.out_rdy_i = 1'b0;
        load(0, 2, 1);
        for (int c = 0; c < 4; c++) begin
            clk_cycle();
            total++;
            if (last_src !== -1 || bus.grant_vld_o !== 1'b1 || bus.grant_o !== 3'd1) begin
                bad++;
                $display("FAIL bp_hold: ack input %0d vld=%b grant=%0d, required none 1 1",
                         last_src, bus.grant_vld_o, bus.grant_o);
            end
        end
        bus.out_rdy_i = 1'b1;
        push_pkt(0, 2);
        drain(20);
    endtask

    task automatic test_owner_bubble();
        do_reset();
        load(0, 3, 1); push_pkt(0, 3);
        clk_cycle();
        clk_cycle();
        hold[0] = 1'b1;
        load(1, 2, 1);
        for (int c = 0; c < 2; c++) begin
            clk_cycle();
            total++;
            if (last_src !== -1 || bus.grant_vld_o !== 1'b1 || bus.grant_o !== 3'd0) begin
                bad++;
                $display("FAIL bubble_hold: ack input %0d vld=%b grant=%0d, required none 1 0",
                         last_src, bus.grant_vld_o, bus.grant_o);
            end
        end
        hold = '0;
        drive();
        push_pkt(1, 2);
        drain(20);
    endtask

    task automatic test_single_flit();
        do_reset();
        for (int i = 0; i < IN_N; i++) load(i, 1, 6);
        for (int r = 0; r < 6; r++)
            for (int i = 0; i < IN_N; i++) push_pkt(i, 1);
        clk_cycle();
        for (int c = 0; c < 6 * IN_N; c++) begin
            clk_cycle();
            total++;
            if (last_src < 0) begin
                bad++;
                $display("FAIL single_bubble: no ack in cycle %0d, required an ack", c);
            end
        end
        total++;
        if (sbq.size() !== 0 || bus.grant_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL single_end: outstanding=%0d vld=%b, required 0 0", sbq.size(), bus.grant_vld_o);
        end
    endtask

    task automatic test_soak();
        int n;
        bit busy;
        do_reset();
        sb_on = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < IN_N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                    rem[i]  = int'($urandom_range(1, 4));
                    sent[i] = 0;
                end
            end
            bus.out_rdy_i = ($urandom_range(0, 3) != 0);
            drive();
            clk_cycle();
        end
        bus.out_rdy_i = 1'b1;
        n = 0;
        busy = 1'b1;
        while (busy && n < 200) begin
            busy = 1'b0;
            for (int i = 0; i < IN_N; i++) if (rem[i] > 0) busy = 1'b1;
            if (busy) clk_cycle();
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL soak_drain: flits still pending after %0d cycles, required none", n);
        end
        sb_on = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        sb_on         = 1'b1;
        hold          = '0;
        owner         = -1;
        bus.req_i     = '0;
        bus.last_i    = '0;
        bus.out_rdy_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_owner_bubble();
        test_single_flit();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
